muldiv_hilo_ctrl: RTL and testbench

- Sequencer between decode and the iterative 32x32 multiplier.
- Owns the architectural HI/LO registers.
- Launches MULT/MULTU on the multiplier, waits for its finish flag and commits the 64-bit product to HI/LO.
- Services MFHI/MFLO/MTHI/MTLO, and stalls the pipeline (op_ready low) while a multiply is in flight.

---
 rtl/muldiv_hilo_ctrl.sv | 114 +++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - HI/LO owner and launch/commit sequencer for the iterative 32x32 multiplier
module muldiv_hilo_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        op_ready,
    input  logic        flush,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_y,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MFHI  = 3'b011;
    localparam logic [2:0] OP_MFLO  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign op_ready = (state == S_IDLE) & ~flush;
    assign busy     = (state == S_RUN);
    assign accept   = op_valid & op_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            rd_data     <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            mul_signed  <= 1'b0;
            mul_start   <= 1'b0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mul_start   <= 1'b0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                mul_a      <= rs_val;
                                mul_b      <= rt_val;
                                mul_signed <= (op == OP_MULT);
                                mul_start  <= 1'b1;
                                cnt        <= '0;
                                state      <= S_RUN;
                            end
                            OP_MFHI: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    // cnt==0 is the mul_start cycle; a finish flag there is stale
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (mul_done && (cnt != '0)) begin
                        hi    <= mul_y[63:32];
                        lo    <= mul_y[31:0];
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb/tb_muldiv_hilo_ctrl.sv - vector table, corner sequences and randomized model check for muldiv_hilo_ctrl
module tb_muldiv_hilo_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        op_ready;
    logic        flush = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        mul_start;
    logic        mul_signed;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_done = 1'b0;
    logic [63:0] mul_y = '0;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_hilo_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .op_ready(op_ready), .flush(flush),
        .rd_data(rd_data), .rd_valid(rd_valid), .mul_start(mul_start),
        .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_y(mul_y), .busy(busy), .done(done),
        .timeout_err(timeout_err), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_rv;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        return sgn ? 64'(sa * sb) : ua * ub;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] d, input string tag);
        bit          is_rd;
        logic [31:0] exp_rd;
        is_rd  = (o == 3'b011) || (o == 3'b100);
        exp_rd = (o == 3'b011) ? m_hi : m_lo;
        op_valid = 1'b1;
        op = o;
        rs_val = d;
        #1;
        chk({tag, "_ready"}, op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
        if (o == 3'b101) m_hi = d;
        if (o == 3'b110) m_lo = d;
        chk({tag, "_rd_valid"}, rd_valid, is_rd);
        if (is_rd) chk({tag, "_rd_data"}, rd_data, exp_rd);
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    // lat: cycle index after accept (0 = mul_start cycle) when mul_done rises, <1 = never
    // fl:  cycle index when flush rises, <0 = never
    task automatic run_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int fl, input bit early, input bit hold_mflo,
                           input string tag);
        logic [63:0] y;
        int          t_end;
        int          kind;
        bit          bad;
        y = ref_product(sgn, a, b);
        t_end = TIMEOUT - 1;
        kind = 2;
        if (lat >= 1 && lat <= t_end) begin t_end = lat; kind = 0; end
        if (fl >= 0 && fl <= t_end) begin t_end = fl; kind = 1; end

        op_valid = 1'b1;
        op = sgn ? 3'b001 : 3'b010;
        rs_val = a;
        rt_val = b;
        #1;
        chk({tag, "_ready_idle"}, op_ready, 1'b1);
        tick();
        if (hold_mflo) op = 3'b100;
        else op_valid = 1'b0;
        bad = 1'b0;
        for (int c = 0; c <= t_end; c++) begin
            mul_done = (c == lat) || (early && c == 0);
            mul_y = (early && c == 0) ? ~y : y;
            flush = (c == fl);
            if (c == 0) begin
                chk({tag, "_start"}, {mul_start, mul_signed}, {1'b1, sgn});
                chk({tag, "_operands"}, {mul_a, mul_b}, {a, b});
            end else if (mul_start !== 1'b0 || mul_a !== a || mul_b !== b || mul_signed !== sgn) begin
                bad = 1'b1;
            end
            if (op_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || timeout_err !== 1'b0 || rd_valid !== 1'b0)
                bad = 1'b1;
            tick();
        end
        mul_done = 1'b0;
        flush = 1'b0;
        chk({tag, "_run_stable"}, bad, 1'b0);
        if (kind == 0) {m_hi, m_lo} = y;
        chk({tag, "_end_pulses"}, {done, timeout_err, busy}, {kind == 0, kind == 2, 1'b0});
        chk({tag, "_hilo"}, {hi, lo}, {m_hi, m_lo});
        if (hold_mflo) begin
            chk({tag, "_ready_after"}, op_ready, 1'b1);
            tick();
            op_valid = 1'b0;
            chk({tag, "_held_mflo"}, {rd_valid, rd_data}, {1'b1, m_lo});
        end else begin
            tick();
        end
        chk({tag, "_pulse_width"}, {done, timeout_err}, 2'b00);
    endtask

    initial begin
        vecs[0] = '{3'b101, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'h0};
        vecs[1] = '{3'b110, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h0};
        vecs[2] = '{3'b011, 32'h0BADF00D, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{3'b100, 32'h0BADF00D, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678};
        vecs[4] = '{3'b000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h0};
        vecs[5] = '{3'b111, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h0};
        vecs[6] = '{3'b110, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[7] = '{3'b100, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};

        repeat (3) tick();
        chk("reset_outputs", {hi, lo, rd_data, mul_a, mul_b, mul_start, mul_signed, rd_valid, done, timeout_err, busy},
            '0);
        rst_n = 1'b1;
        tick();
        chk("reset_ready", op_ready, 1'b1);

        foreach (vecs[i]) begin
            op_valid = 1'b1;
            op = vecs[i].op;
            rs_val = vecs[i].rs;
            tick();
            op_valid = 1'b0;
            chk($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].exp_rv);
            if (vecs[i].exp_rv) chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].exp_rd);
            tick();
            chk($sformatf("vec%0d_rd_pulse", i), rd_valid, 1'b0);
        end
        m_hi = 32'hDEADBEEF;
        m_lo = 32'hCAFEF00D;

        run_mul(1'b0, 32'hFFFFFFFF, 32'd2, 33, -1, 1'b0, 1'b0, "multu");
        chk("multu_value", {hi, lo}, 64'h00000001_FFFFFFFE);

        run_mul(1'b1, 32'hFFFFFFFD, 32'd5, 7, -1, 1'b0, 1'b1, "mult_hold");
        chk("mult_value", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

        run_mul(1'b1, 32'h00001234, 32'h00005678, -1, -1, 1'b0, 1'b0, "timeout");
        issue(3'b011, 32'h0, "mfhi_after_to");

        run_mul(1'b0, 32'h11111111, 32'h3, 10, 10, 1'b0, 1'b0, "flush_done");
        mul_done = 1'b1;
        mul_y = 64'hA5A5A5A5_5A5A5A5A;
        tick();
        mul_done = 1'b0;
        chk("late_done_ignored", {done, hi, lo}, {1'b0, m_hi, m_lo});

        run_mul(1'b0, 32'h7, 32'h9, 5, -1, 1'b1, 1'b0, "early_done");
        run_mul(1'b1, 32'h80000000, 32'h80000000, TIMEOUT - 1, -1, 1'b0, 1'b0, "done_at_last");

        flush = 1'b1;
        op_valid = 1'b1;
        op = 3'b101;
        rs_val = 32'h55555555;
        #1;
        chk("flush_idle_ready", op_ready, 1'b0);
        tick();
        flush = 1'b0;
        op_valid = 1'b0;
        chk("flush_idle_no_accept", {hi, lo}, {m_hi, m_lo});

        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r < 4) begin
                issue(3'(3 + r), $urandom, $sformatf("rnd%0d_reg", n));
            end else begin
                run_mul(r[0], $urandom, $urandom, $urandom_range(1, 45),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 45)) : -1,
                        $urandom_range(0, 1) == 1, 1'b0, $sformatf("rnd%0d_mul", n));
            end
        end

        op_valid = 1'b1;
        op = 3'b001;
        rs_val = 32'h1234;
        rt_val = 32'h5678;
        tick();
        op_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {hi, lo, rd_data, mul_a, mul_b, mul_start, mul_signed, rd_valid, done, timeout_err, busy}, '0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_state", {op_ready, hi, lo}, {1'b1, 64'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
